// File: rtl/isqrt_pipe_elastic.sv
// Pipelined integer square root with remainder and a sideband tag.
// y = floor(sqrt(x)), r = x - y*y, computed by the restoring digit-by-digit
// method, two radicand bits per slice, W/2 slices spread evenly over
// N_STAGES register stages. Each stage has a valid/ready-style elastic
// enable: a stage loads when it is empty or when the stage after it loads.
// W must be even and >= 4; N_STAGES must divide W/2.
module isqrt_pipe_elastic #(
  parameter int W        = 32,
  parameter int N_STAGES = 4,
  parameter int TAG_W    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W/2-1:0]   out_y,
  output logic [W/2:0]     out_r,
  output logic [TAG_W-1:0] out_tag
);

  localparam int HW  = W / 2;
  localparam int SPS = HW / N_STAGES;

  // Runs the SPS slices owned by one stage. The result y lives in the low
  // half once all slices have run; m walks down two bits per slice.
  function automatic logic [2*W-1:0] stage_eval(
    input logic [W-1:0] x_in,
    input logic [W-1:0] y_in,
    input int           stage
  );
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] b;
    logic [W-1:0] m;
    x = x_in;
    y = y_in;
    for (int j = 0; j < SPS; j++) begin
      m = W'(1) << (W - 2 - 2 * (stage * SPS + j));
      b = y | m;
      y = y >> 1;
      if (x >= b) begin
        x = x - b;
        y = y | m;
      end
    end
    return {x, y};
  endfunction

  logic [N_STAGES-1:0] v_q;
  logic [N_STAGES-1:0] adv;
  logic [W-1:0]        x_q     [N_STAGES];
  logic [W-1:0]        y_q     [N_STAGES];
  logic [TAG_W-1:0]    tag_q   [N_STAGES];

  logic                src_v   [N_STAGES];
  logic [W-1:0]        src_x   [N_STAGES];
  logic [W-1:0]        src_y   [N_STAGES];
  logic [TAG_W-1:0]    src_tag [N_STAGES];
  logic [W-1:0]        nxt_x   [N_STAGES];
  logic [W-1:0]        nxt_y   [N_STAGES];

  // Per-stage source selection and combinational slice evaluation.
  for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign src_v[s]   = in_valid;
      assign src_x[s]   = in_x;
      assign src_y[s]   = '0;
      assign src_tag[s] = in_tag;
    end else begin : g_rest
      assign src_v[s]   = v_q[s-1];
      assign src_x[s]   = x_q[s-1];
      assign src_y[s]   = y_q[s-1];
      assign src_tag[s] = tag_q[s-1];
    end
    assign {nxt_x[s], nxt_y[s]} = stage_eval(src_x[s], src_y[s], s);
  end

  // Advance enables ripple back from the consumer: a stage may load when it
  // is empty or its successor is loading, so bubbles collapse under stall.
  always_comb begin : p_adv
    logic a;
    adv = '0;
    a = ~v_q[N_STAGES-1] | out_ready;
    adv[N_STAGES-1] = a;
    for (int s = N_STAGES - 2; s >= 0; s--) begin
      a = ~v_q[s] | a;
      adv[s] = a;
    end
  end

  // Stage registers: load on advance, otherwise hold everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int s = 0; s < N_STAGES; s++) begin
        x_q[s]   <= '0;
        y_q[s]   <= '0;
        tag_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < N_STAGES; s++) begin
        if (adv[s]) begin
          v_q[s]   <= src_v[s];
          x_q[s]   <= nxt_x[s];
          y_q[s]   <= nxt_y[s];
          tag_q[s] <= src_tag[s];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[N_STAGES-1];
  assign out_y     = y_q[N_STAGES-1][HW-1:0];
  assign out_r     = x_q[N_STAGES-1][HW:0];
  assign out_tag   = tag_q[N_STAGES-1];

  // The upper bits of the final x/y are always zero after the last slice.
  logic unused_hi;
  assign unused_hi = ^{x_q[N_STAGES-1][W-1:HW+1], y_q[N_STAGES-1][W-1:HW]};

endmodule

// File: tb/tb_isqrt_pipe_elastic.sv
// Scoreboard bench for isqrt_pipe_elastic: accepted operands push the
// reference result; a monitor pops and compares on every output handshake.
module tb_isqrt_pipe_elastic;

  localparam int W        = 32;
  localparam int N_STAGES = 4;
  localparam int TAG_W    = 4;
  localparam int HW       = W / 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_x = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [HW-1:0]    out_y;
  logic [HW:0]      out_r;
  logic [TAG_W-1:0] out_tag;

  isqrt_pipe_elastic #(.W(W), .N_STAGES(N_STAGES), .TAG_W(TAG_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_r    (out_r),
    .out_tag  (out_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [HW-1:0]    y;
    logic [HW:0]      r;
    logic [TAG_W-1:0] tag;
    longint           cyc;
  } exp_t;

  exp_t   sb[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     n_out = 0;
  longint cyc = 0;
  int     or_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
  bit     chk_lat = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: largest y with y*y <= x, found by binary search.
  function automatic void ref_isqrt(input logic [W-1:0] x, output logic [HW-1:0] y,
                                    output logic [HW:0] r);
    logic [2*W-1:0] lo, hi, mid, xx, rr;
    xx = (2*W)'(x);
    lo = '0;
    hi = ((2*W)'(1) << HW) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= xx) lo = mid;
      else hi = mid - 1;
    end
    rr = xx - lo * lo;
    y  = lo[HW-1:0];
    r  = rr[HW:0];
  endfunction

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Accept recorder: the accept happens at the next rising edge.
  always @(negedge clock) begin : p_acc
    exp_t e;
    if (reset_n && in_valid && in_ready) begin
      ref_isqrt(in_x, e.y, e.r);
      e.tag = in_tag;
      e.cyc = cyc;
      sb.push_back(e);
    end
  end

  // Monitor: compare on output handshake, and check outputs hold while stalled.
  logic [HW+HW+1+TAG_W-1:0] hold_data;
  bit stall_prev = 1'b0;
  always @(negedge clock) begin : p_mon
    exp_t e;
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 128'(out_valid), 128'(1));
        check("hold_data", 128'({out_y, out_r, out_tag}), 128'(hold_data));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_out: y=%0h r=%0h tag=%0h with no operand outstanding",
                   out_y, out_r, out_tag);
        end else begin
          e = sb.pop_front();
          check("y", 128'(out_y), 128'(e.y));
          check("r", 128'(out_r), 128'(e.r));
          check("tag", 128'(out_tag), 128'(e.tag));
          if (chk_lat) check("latency", 128'(cyc - e.cyc), 128'(N_STAGES));
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_data  = {out_y, out_r, out_tag};
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [TAG_W-1:0] t, output int waited);
    bit acc;
    waited   = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_tag   = t;
    forever begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      if (acc) break;
      waited++;
      if (waited > 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: operand %0h not accepted", x);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(posedge clock);
      #1;
      t++;
    end
    check("drain_left", 128'(sb.size()), 128'(0));
    repeat (2) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin : p_wd
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] dx [8];

  initial begin : p_main
    int w, acc, late, outs0;
    longint c0;
    logic [W-1:0] x;
    logic [W-1:0] k;

    dx = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'hFFFF_FFFF, 32'd1000000, 32'd99};

    // Reset state
    #3;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_y", 128'(out_y), 128'(0));
    check("rst_out_r", 128'(out_r), 128'(0));
    check("rst_out_tag", 128'(out_tag), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    or_mode = 0;
    @(posedge clock);
    #1;

    // Directed isolated operands with latency check
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(dx[i], TAG_W'(i + 3), w);
      drain();
    end

    // Full-rate stream
    late = 0;
    c0 = cyc;
    for (int i = 0; i < 64; i++) begin
      send($urandom, TAG_W'(i), w);
      late += w;
    end
    check("stream_stalls", 128'(late), 128'(0));
    check("stream_cycles", 128'(cyc - c0), 128'(64));
    drain();

    // Back-pressure: fill pipe with consumer stalled
    chk_lat = 1'b0;
    or_mode = 2;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_x   = $urandom;
      in_tag = TAG_W'(i);
      @(negedge clock);
      if (!in_ready) break;
      acc++;
      @(posedge clock);
      #1;
    end
    check("bp_accepts", 128'(acc), 128'(N_STAGES));
    late = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      @(negedge clock);
      if (in_ready) late++;
    end
    check("bp_in_ready_low", 128'(late), 128'(0));
    // Release while still offering operands: simultaneous in/out on full pipe
    or_mode = 0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) send($urandom, TAG_W'(i + 8), w);
    drain();

    // Reset with 3 operands in flight
    for (int i = 0; i < 3; i++) send($urandom | 32'h8000_0000, TAG_W'(i + 1), w);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_out_y", 128'(out_y), 128'(0));
    check("mid_rst_out_r", 128'(out_r), 128'(0));
    check("mid_rst_out_tag", 128'(out_tag), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    sb.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk_lat = 1'b1;
    outs0 = n_out;
    send(32'd99, 4'hA, w);
    drain();
    repeat (6) begin
      @(posedge clock);
      #1;
    end
    check("post_rst_outputs", 128'(n_out - outs0), 128'(1));

    // Random traffic with random back-pressure
    chk_lat = 1'b0;
    or_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clock);
          #1;
        end
      end
      case ($urandom_range(0, 7))
        0: x = W'($urandom_range(0, 20));
        1: begin
          k = W'($urandom_range(0, 65535));
          x = k * k + W'($urandom_range(0, 2)) - W'(1);
        end
        2: x = ~W'($urandom_range(0, 3));
        default: x = $urandom;
      endcase
      send(x, TAG_W'($urandom), w);
    end
    or_mode = 0;
    drain();
    check("sb_empty", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
